// File: rtl/serial_rx_fifo.sv
// Serial link receiver: reassembles LSB-first frames into words, optionally checks even parity,
// and buffers complete words in a first-word-fall-through FIFO with a valid/ready output.
module serial_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HAS_PARITY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  serial_in_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o,
    output logic                  overflow_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e                  state_q, state_d;
    logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic                    word_done;
    logic                    par_err_d, frm_err_d, ovf_d;
    logic                    par_err_q, frm_err_q, ovf_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]         occ_q, occ_d;
    logic                    full, empty, push, pop;

    // Frame assembly; a start strobe always wins and reopens a frame at bit 0.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (enable_i) begin
            if (start_i) begin
                frm_err_d  = (state_q != StIdle);
                shift_d    = '0;
                shift_d[0] = serial_in_i;
                bit_cnt_d  = BitCntW'(1);
                state_d    = StData;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StData: begin
                        shift_d[bit_cnt_q] = serial_in_i;
                        if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            if (HAS_PARITY != 0) begin
                                state_d = StParity;
                            end else begin
                                state_d   = StIdle;
                                word_done = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitCntW'(1);
                        end
                    end
                    StParity: begin
                        state_d = StIdle;
                        if ((^shift_q) ^ serial_in_i) begin
                            par_err_d = 1'b1;
                        end else begin
                            word_done = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    assign hold_d     = word_done ? shift_d : hold_q;
    assign hold_vld_d = word_done;

    assign full  = (occ_q == OccW'(FIFO_DEPTH));
    assign empty = (occ_q == '0);
    assign pop   = !empty && ready_i;
    // A full FIFO still takes the held word when the head leaves on the same edge.
    assign push  = hold_vld_q && (!full || pop);
    assign ovf_d = hold_vld_q && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= hold_q;
            end
        end
    end

    assign parallel_out_o = mem_q[rd_ptr_q];
    assign valid_o        = !empty;
    assign fifo_full_o    = full;
    assign fifo_empty_o   = empty;
    assign overflow_o     = ovf_q;
    assign parity_err_o   = par_err_q;
    assign frame_err_o    = frm_err_q;

endmodule
